cussen_stream_encoder: RTL and testbench
========================================

Name: cussen_stream_encoder

Overview:
Parametrised, multi-cycle successor to the 9-byte sort/dedup/delta block. It accepts one N-element vector per valid/ready transaction. It sorts the vector ascending with an iterative odd-even transposition sorter, compacts duplicates, and emits either successive differences or raw unique values, plus a per-input pointer into the unique list. It sits between the input capture stage and the downstream compression/packing logic.

Parameters:
N, 9, number of elements per vector (N >= 2)
W, 8, element width in bits
IW, $clog2(N), derived (localparam): pointer width
CW, $clog2(N+1), derived (localparam): count width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  N*W  element k at [k*W +: W]
in_delta_en  in  1  1 = delta output, 0 = raw unique values; captured with in_data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  N*W  element k at [k*W +: W]
out_ptr  out  N*IW  pointer for input element k at [k*IW +: IW]
out_count  out  CW  number of unique values, 1..N
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-released use): state goes to IDLE. All of out_data, out_ptr, out_count, out_valid and busy are 0; in_ready is 1. Reset mid-operation discards the in-flight vector with no partial output.
- FSM states: IDLE, SORT, DEDUP, MAP, DELTA, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the working array and the copy array, latch in_delta_en, then go to SORT.
- SORT: N cycles, each performing one full compare-exchange pass. Even cycles compare pairs (0,1),(2,3)…; odd cycles compare (1,2),(3,4)…. Sorting is unsigned ascending. Zero is an ordinary value with no skip rule. Go to DEDUP after pass N.
- DEDUP: N cycles, scanning sorted index i=0..N-1 with write index wr. Element 0 is always kept. Element i is kept if it differs from its predecessor. Kept elements are compacted to u[0..count-1], and slots >= count are cleared to 0. Then out_count=count and the FSM goes to MAP.
- MAP: N cycles. Cycle k sets ptr[k] = number of u[j], j<count, strictly less than copy[k]. This equals the index of copy[k] in u. Then go to DELTA.
- DELTA: 1 cycle.
  - If delta_en=1: out[0]=u[0]; out[k]=u[k]-u[k-1] for 1<=k<count; out[k]=0 for k>=count. Differences are W-bit and never wrap, because u is strictly ascending.
  - If delta_en=0: out[k]=u[k].
  - Then go to DONE with out_valid=1.
- Latency: out_valid rises 3N+2 rising edges after the accepting edge (29 for N=9).
- DONE: out_data, out_ptr and out_count are held stable while out_valid&&!out_ready. On out_valid&&out_ready, drop out_valid and return to IDLE. in_ready rises the following cycle, giving one bubble and no overlap.
- in_valid outside IDLE is ignored (in_ready=0). in_data may change freely after acceptance.
- Output registers keep their last values after the handshake until the next DELTA cycle.

Decomposition:
- Package cussen_pkg holds:
  - the state enum typedef (6 states);
  - default N/W localparams;
  - a function computing IW/CW.
- One sub-module, cussen_cmp_swap: W-bit unsigned compare-exchange (lo/hi outputs). It is instantiated N/2 times per pass parity and muxed by cycle parity in SORT.

Test Plan:
1. N=9, W=8, in={5,3,8,3,1,9,5,2,7}, delta_en=1 -> count=7, out={1,1,1,2,2,1,1,0,0}, ptr={3,2,5,2,0,6,3,1,4}, out_valid exactly 29 edges after accept.
2. All nine elements = 42, delta_en=1 -> count=1, out={42,0,0,0,0,0,0,0,0}, ptr all 0.
3. in={0,255,0,128,255,1,0,128,64}, delta_en=0 -> count=5, out={0,1,64,128,255,0,0,0,0}, ptr={0,4,0,3,4,1,0,3,2}.
4. Case 1 with out_ready held low 5 cycles after out_valid -> outputs bit-stable, in_ready=0, second in_valid ignored. Raise out_ready -> out_valid falls, in_ready=1 next cycle, next vector accepted.
5. Assert rst_n=0 mid-SORT (cycle 4 after accept) -> outputs 0 and in_ready=1 immediately (async). After release, case 2 runs cleanly with correct result.
6. N=4, W=4, in={15,0,15,7}, delta_en=1 -> count=3, out={0,7,8,0}, ptr={2,0,2,1}, latency 14 edges.

Source files
------------

// File: rtl/cussen_pkg.sv
// Shared types and sizing helpers for the cussen sort/dedup/delta stream encoder.
package cussen_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SORT,
    S_DEDUP,
    S_MAP,
    S_DELTA,
    S_DONE
  } state_t;

  localparam int DEF_N = 9;
  localparam int DEF_W = 8;

  // Bits needed to index n distinct values (ceil(log2(n))).
  function automatic int idx_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cussen_cmp_swap.sv
// Unsigned compare-exchange cell used by the odd-even transposition sorter.
module cussen_cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic a_lt_b;

  assign a_lt_b = (a < b);
  assign lo     = a_lt_b ? a : b;
  assign hi     = a_lt_b ? b : a;

endmodule

// File: rtl/cussen_stream_encoder.sv
// Multi-cycle vector encoder: sort, dedup, per-element index map, then delta or raw
// unique values, exchanged over valid/ready on both sides.
module cussen_stream_encoder
  import cussen_pkg::*;
#(
  parameter int  N  = DEF_N,
  parameter int  W  = DEF_W,
  localparam int IW = idx_w(N),
  localparam int CW = idx_w(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic          in_delta_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*W-1:0] out_data,
  output logic [N*IW-1:0] out_ptr,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  state_t         state, nxt;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  cidx;

  logic [W-1:0]   s     [N];
  logic [W-1:0]   s_nxt [N];
  logic [W-1:0]   u     [N];
  logic [W-1:0]   cp    [N];
  logic [IW-1:0]  ptr   [N];
  logic [CW-1:0]  wr;
  logic [CW-1:0]  count_r;
  logic           delta_en_r;
  logic           dedup_keep;
  logic [IW-1:0]  map_lt;

  logic [W-1:0]   ev_lo [N/2];
  logic [W-1:0]   ev_hi [N/2];
  logic [W-1:0]   od_lo [N/2];
  logic [W-1:0]   od_hi [N/2];

  logic [W-1:0]   out_r       [N];
  logic [IW-1:0]  out_ptr_r   [N];
  logic [CW-1:0]  out_count_r;

  assign cidx = cnt[IW-1:0];

  // cnt restarts on every state change, so it is the cycle index within a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (in_valid)             nxt = S_SORT;
      S_SORT:  if (cnt == CW'(N - 1))    nxt = S_DEDUP;
      S_DEDUP: if (cnt == CW'(N))        nxt = S_MAP;
      S_MAP:   if (cnt == CW'(N - 1))    nxt = S_DELTA;
      S_DELTA:                           nxt = S_DONE;
      S_DONE:  if (out_ready)            nxt = S_IDLE;
      default:                           nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
  end

  // ---- sort pass: even pairs on even cycles, odd pairs on odd cycles ----
  for (genvar i = 0; i < N / 2; i++) begin : g_even
    cussen_cmp_swap #(.W(W)) u_cs (
      .a(s[2*i]), .b(s[2*i+1]), .lo(ev_lo[i]), .hi(ev_hi[i])
    );
  end

  for (genvar i = 0; i < (N - 1) / 2; i++) begin : g_odd
    cussen_cmp_swap #(.W(W)) u_cs (
      .a(s[2*i+1]), .b(s[2*i+2]), .lo(od_lo[i]), .hi(od_hi[i])
    );
  end

  always_comb begin
    s_nxt = s;
    if (!cnt[0]) begin
      for (int i = 0; i < N / 2; i++) begin
        s_nxt[2*i]   = ev_lo[i];
        s_nxt[2*i+1] = ev_hi[i];
      end
    end else begin
      for (int i = 0; i < (N - 1) / 2; i++) begin
        s_nxt[2*i+1] = od_lo[i];
        s_nxt[2*i+2] = od_hi[i];
      end
    end
  end

  // ---- dedup keep test and index-map rank ----
  assign dedup_keep = (cidx == '0) || (s[cidx] != s[cidx - 1'b1]);

  always_comb begin
    map_lt = '0;
    for (int j = 0; j < N; j++) begin
      if ((CW'(j) < count_r) && (u[j] < cp[cidx])) map_lt = map_lt + 1'b1;
    end
  end

  // Working arrays carry no reset: every field is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            s[k]  <= in_data[k*W +: W];
            cp[k] <= in_data[k*W +: W];
          end
          delta_en_r <= in_delta_en;
          wr         <= '0;
        end
      end
      S_SORT: s <= s_nxt;
      S_DEDUP: begin
        if (cnt == CW'(N)) begin
          count_r <= wr;
          for (int j = 0; j < N; j++) begin
            if (CW'(j) >= wr) u[j] <= '0;
          end
        end else if (dedup_keep) begin
          u[wr[IW-1:0]] <= s[cidx];
          wr            <= wr + 1'b1;
        end
      end
      S_MAP: ptr[cidx] <= map_lt;
      default: ;
    endcase
  end

  // ---- output registers, loaded only in DELTA ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        out_r[k]     <= '0;
        out_ptr_r[k] <= '0;
      end
      out_count_r <= '0;
    end else if (state == S_DELTA) begin
      out_r[0] <= u[0];
      for (int k = 1; k < N; k++) begin
        if (!delta_en_r)             out_r[k] <= u[k];
        else if (CW'(k) < count_r)   out_r[k] <= u[k] - u[k-1];
        else                         out_r[k] <= '0;
      end
      for (int k = 0; k < N; k++) out_ptr_r[k] <= ptr[k];
      out_count_r <= count_r;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign out_data[k*W +: W]  = out_r[k];
    assign out_ptr[k*IW +: IW] = out_ptr_r[k];
  end
  assign out_count = out_count_r;

endmodule

// File: tb/tb_cussen_stream_encoder.sv
// Bench for cussen_stream_encoder: table of vectors with a scoreboard queue, plus
// backpressure, mid-sort reset and a small N=4/W=4 instance.
module tb_cussen_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, in_delta_en = 1'b0;
  logic [71:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0, busy;
  logic [71:0] out_data;
  logic [35:0] out_ptr;
  logic [3:0]  out_count;

  logic        in_valid_b = 1'b0, in_ready_b, in_delta_en_b = 1'b0;
  logic [15:0] in_data_b = '0;
  logic        out_valid_b, out_ready_b = 1'b1, busy_b;
  logic [15:0] out_data_b;
  logic [7:0]  out_ptr_b;
  logic [2:0]  out_count_b;

  always #5 clk = ~clk;

  cussen_stream_encoder #(.N(9), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_delta_en(in_delta_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ptr(out_ptr),
    .out_count(out_count), .busy(busy)
  );

  cussen_stream_encoder #(.N(4), .W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_delta_en(in_delta_en_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_ptr(out_ptr_b),
    .out_count(out_count_b), .busy(busy_b)
  );

  typedef struct {
    logic [71:0] din;
    logic        den;
    logic [71:0] dout;
    logic [35:0] ptr;
    logic [3:0]  cnt;
  } vec_t;

  typedef int a9_t[9];

  vec_t tbl[6];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pk8(input a9_t a);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = a[k][7:0];
    return r;
  endfunction

  function automatic logic [35:0] pk4(input a9_t a);
    logic [35:0] r;
    for (int k = 0; k < 9; k++) r[k*4 +: 4] = a[k][3:0];
    return r;
  endfunction

  // Reference: build the sorted distinct list by insertion, then look up indices.
  function automatic vec_t model(input logic [71:0] din, input logic den);
    int   uq[9];
    int   cnt, v, pos, val;
    bit   found;
    vec_t r;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      v = int'(din[i*8 +: 8]);
      found = 1'b0;
      for (int j = 0; j < cnt; j++) if (uq[j] == v) found = 1'b1;
      if (!found) begin
        pos = cnt;
        while (pos > 0 && uq[pos-1] > v) begin
          uq[pos] = uq[pos-1];
          pos--;
        end
        uq[pos] = v;
        cnt++;
      end
    end
    r.din = din; r.den = den; r.cnt = cnt[3:0]; r.dout = '0; r.ptr = '0;
    for (int k = 0; k < cnt; k++) begin
      val = (den && k > 0) ? uq[k] - uq[k-1] : uq[k];
      r.dout[k*8 +: 8] = val[7:0];
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < cnt; j++)
        if (uq[j] == int'(din[i*8 +: 8])) r.ptr[i*4 +: 4] = j[3:0];
    return r;
  endfunction

  task automatic apply(input vec_t v);
    int   lat;
    vec_t e;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_data = v.din; in_delta_en = v.den; in_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = ~v.din; in_delta_en = ~v.den;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, 29);
    e = sb_q.pop_front();
    check("out_data", out_data, e.dout);
    check("out_ptr", out_ptr, e.ptr);
    check("out_count", out_count, e.cnt);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_back", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    a9_t         a;
    logic [71:0] d, hold_d;
    logic [35:0] hold_p;
    logic [3:0]  hold_c;
    int          lat;

    a = '{5, 3, 8, 3, 1, 9, 5, 2, 7};        tbl[0].din  = pk8(a);
    a = '{1, 1, 1, 2, 2, 1, 1, 0, 0};        tbl[0].dout = pk8(a);
    a = '{3, 2, 5, 2, 0, 6, 3, 1, 4};        tbl[0].ptr  = pk4(a);
    tbl[0].cnt = 4'd7; tbl[0].den = 1'b1;
    a = '{42, 42, 42, 42, 42, 42, 42, 42, 42}; tbl[1].din = pk8(a);
    a = '{42, 0, 0, 0, 0, 0, 0, 0, 0};       tbl[1].dout = pk8(a);
    tbl[1].ptr = '0; tbl[1].cnt = 4'd1; tbl[1].den = 1'b1;
    a = '{0, 255, 0, 128, 255, 1, 0, 128, 64}; tbl[2].din = pk8(a);
    a = '{0, 1, 64, 128, 255, 0, 0, 0, 0};   tbl[2].dout = pk8(a);
    a = '{0, 4, 0, 3, 4, 1, 0, 3, 2};        tbl[2].ptr  = pk4(a);
    tbl[2].cnt = 4'd5; tbl[2].den = 1'b0;
    for (int t = 3; t < 6; t++) begin
      for (int k = 0; k < 9; k++)
        d[k*8 +: 8] = (t == 5) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      tbl[t] = model(d, (t != 4));
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ptr", out_ptr, '0);
    check("rst_out_count", out_count, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      apply(tbl[t]);
      release_out();
    end

    // Backpressure: hold results while a second vector is offered and ignored.
    apply(tbl[0]);
    hold_d = out_data; hold_p = out_ptr; hold_c = out_count;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {9{8'd200}}; in_delta_en = 1'b0;
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_data_hold", out_data, tbl[0].dout);
      check("bp_ptr_hold", out_ptr, hold_p);
      check("bp_count_hold", out_count, hold_c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    check("bp_data_after", out_data, hold_d);
    apply(tbl[2]);
    release_out();

    // Asynchronous reset four edges into SORT discards the vector.
    @(negedge clk);
    in_data = tbl[0].din; in_delta_en = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_out_ptr", out_ptr, '0);
    check("mid_rst_out_count", out_count, '0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(tbl[1]);
    release_out();

    // Small instance: N=4, W=4.
    @(negedge clk);
    check("b_in_ready", in_ready_b, 1'b1);
    in_data_b = 16'h7F0F; in_delta_en_b = 1'b1; in_valid_b = 1'b1;
    @(posedge clk);
    #1 in_valid_b = 1'b0; in_data_b = '0;
    lat = 0;
    while (!out_valid_b && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("b_latency", lat, 14);
    check("b_out_data", out_data_b, 16'h0870);
    check("b_out_ptr", out_ptr_b, 8'h62);
    check("b_out_count", out_count_b, 3'd3);
    @(posedge clk);
    #1 check("b_in_ready_back", in_ready_b, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
